wb_master_port: RTL and testbench
=================================

// Module: wb_master_port
// PURPOSE
// - Wishbone pipelined-mode initiator; bridges one CPU-side load/store request to one single-beat bus cycle on the 64-bit bus.
// - Drives stb/cyc/adr/sel/dat/we; honours stall and ack from slaves (bios, peripherals); returns aligned, extended read data.
// - One outstanding transaction; sits between the CPU load/store/fetch unit and the shared bus.
// PARAMETERS
// - TIMEOUT_CYCLES  default 255  cycles in REQ+WAIT without ack before abort (only with WB_MASTER_TIMEOUT_EN)
// - CNT_BITS        default 8    width of timeout counter; TIMEOUT_CYCLES < 2**CNT_BITS
// PORTS
// - i_clk          in   1   clock, all state on posedge
// - i_reset_n      in   1   asynchronous, active-low reset
// - i_req_valid    in   1   request present
// - o_req_ready    out  1   high only in IDLE; request accepted when valid&ready
// - i_req_addr     in   64  byte address
// - i_req_wdata    in   64  store data, right-justified
// - i_req_we       in   1   1=store, 0=load
// - i_req_size     in   2   0=byte 1=half 2=word 3=dword
// - i_req_unsigned in   1   1=zero-extend load, 0=sign-extend
// - o_rsp_valid    out  1   one-cycle response pulse, no backpressure
// - o_rsp_rdata    out  64  load data, extended; 0 for stores/errors
// - o_rsp_err      out  1   misaligned or timeout; qualified by o_rsp_valid
// - o_wb_adr       out  64  {addr[63:3],3'b0}
// - o_wb_dat       out  64  store data shifted to lane addr[2:0]*8
// - o_wb_we/o_wb_sel/o_wb_stb/o_wb_cyc  out  1/8/1/1  Wishbone control
// - i_wb_dat       in   64  read data from slave
// - i_wb_ack/i_wb_stall  in  1/1  slave handshake
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE; all outputs 0 except o_req_ready=1; counter=0. Reset mid-cycle drops cyc/stb at once, no response.
// - States: IDLE, REQ (cyc=1,stb=1), WAIT (cyc=1,stb=0), RSP (rsp_valid=1, cyc=0).
// - IDLE: on valid&ready latch request; misaligned (addr mod 2**size != 0) -> RSP with err=1, no bus cycle; else -> REQ.
// - REQ: stall=1 -> stay; stall=0&ack=1 -> RSP; stall=0&ack=0 -> WAIT.
// - WAIT: ack=1 -> RSP; else stay.
// - RSP: one cycle, -> IDLE. Minimum latency accept->rsp_valid = 2 cycles; back-to-back issue every 3 cycles.
// - ack in IDLE/RSP ignored. adr/dat/sel/we held stable for the whole cyc.
// - sel: size mask (01,03,0F,FF) << addr[2:0]. wdata << addr[2:0]*8.
// - Load: i_wb_dat captured on ack edge, >> addr[2:0]*8, truncated to size, sign/zero-extended to 64 per i_req_unsigned; size=3 unchanged.
// - Store response: rdata=0, err=0.
// CONFIGURATION
// - WB_MASTER_TIMEOUT_EN defined: counter clears on entry to REQ, increments each REQ/WAIT cycle; reaching TIMEOUT_CYCLES without ack -> cyc/stb drop, RSP with err=1, rdata=0.
// - Undefined: no counter; REQ/WAIT wait indefinitely; o_rsp_err only for misalignment.
// TESTING
// - Load dword addr 0x100, slave stall=0, ack same cycle, dat=0x1122334455667788 -> sel=FF, rsp 2 cycles after accept, rdata=0x1122334455667788, err=0.
// - Signed byte load addr 0x103, dat=0x00000000_80000000 -> sel=0x08, rdata=0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
// - Half store addr 0x106 data 0xBEEF, stall=1 for 3 cycles -> stb high 4 cycles, adr 0x100, sel=0xC0, dat=0xBEEF<<48; rsp err=0.
// - Word load addr 0x102 -> no cyc asserted, rsp next-next cycle err=1 rdata=0.
// - TIMEOUT_EN, TIMEOUT_CYCLES=8, no ack -> cyc drops after 8 cycles, rsp err=1; without macro cyc stays high 100+ cycles.
// - Assert i_reset_n=0 in WAIT -> cyc/stb/rsp_valid 0 same cycle, ready=1 after release, next load completes normally.

Source files
------------

// File: rtl/wb_master_port.sv
// wb_master_port: single-outstanding Wishbone pipelined-mode initiator bridging one CPU load/store to one bus beat.
// Optional bus-timeout abort is compiled in when WB_MASTER_TIMEOUT_EN is defined.
module wb_master_port #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_BITS       = 8
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  // CPU-side request
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  // CPU-side response
  output logic        o_rsp_valid,
  output logic [63:0] o_rsp_rdata,
  output logic        o_rsp_err,
  // Wishbone initiator
  output logic [63:0] o_wb_adr,
  output logic [63:0] o_wb_dat,
  output logic        o_wb_we,
  output logic [7:0]  o_wb_sel,
  output logic        o_wb_stb,
  output logic        o_wb_cyc,
  input  logic [63:0] i_wb_dat,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RSP
  } state_t;

  state_t      state_q, state_d;

  // Latched request, held for the whole bus cycle
  logic [2:0]  lane_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic        we_q;
  logic [63:0] adr_q;
  logic [63:0] dat_q;
  logic [7:0]  sel_q;

  logic [63:0] rdata_q;
  logic        err_q;

  logic        req_fire;
  logic        misaligned;
  logic        bus_done;
  logic        timeout_hit;
  logic        rsp_load;
  logic        rsp_err_d;
  logic [63:0] rsp_rdata_d;
  logic [7:0]  size_sel;
  logic [63:0] size_mask;
  logic [7:0]  lane_sel;
  logic [63:0] lane_dat;
  logic [63:0] rd_shifted;
  logic [63:0] load_ext;

  assign req_fire = i_req_valid && o_req_ready;

  // Request decode: byte-enable width, store-data mask, natural-alignment check
  always_comb begin
    // NOTE: every combinational output is given a default before the case so no path infers a latch.
    size_sel   = 8'h01;
    size_mask  = 64'h0000_0000_0000_00FF;
    misaligned = 1'b0;
    case (i_req_size)
      2'd0: begin
        size_sel  = 8'h01;
        size_mask = 64'h0000_0000_0000_00FF;
      end
      2'd1: begin
        size_sel   = 8'h03;
        size_mask  = 64'h0000_0000_0000_FFFF;
        misaligned = i_req_addr[0];
      end
      2'd2: begin
        size_sel   = 8'h0F;
        size_mask  = 64'h0000_0000_FFFF_FFFF;
        misaligned = |i_req_addr[1:0];
      end
      default: begin
        size_sel   = 8'hFF;
        size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        misaligned = |i_req_addr[2:0];
      end
    endcase
  end

  assign lane_sel = size_sel << i_req_addr[2:0];
  assign lane_dat = (i_req_wdata & size_mask) << {i_req_addr[2:0], 3'b000};

  // Load path: bring the addressed lane down to bit 0, then truncate and extend
  assign rd_shifted = i_wb_dat >> {lane_q, 3'b000};

  always_comb begin
    load_ext = rd_shifted;
    case (size_q)
      2'd0: load_ext = unsigned_q ? {56'd0, rd_shifted[7:0]}
                                  : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1: load_ext = unsigned_q ? {48'd0, rd_shifted[15:0]}
                                  : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2: load_ext = unsigned_q ? {32'd0, rd_shifted[31:0]}
                                  : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // An ack only completes the beat once the slave has taken stb (no stall)
  assign bus_done = i_wb_ack &&
                    ((state_q == ST_WAIT) || ((state_q == ST_REQ) && !i_wb_stall));

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  logic [CNT_BITS-1:0] cnt_q;

  assign timeout_hit = ((state_q == ST_REQ) || (state_q == ST_WAIT)) && (cnt_q == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else if (req_fire && !misaligned) begin
      cnt_q <= '0;
    end else if ((state_q == ST_REQ) || (state_q == ST_WAIT)) begin
      cnt_q <= cnt_q + CNT_BITS'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and response capture
  always_comb begin
    state_d     = state_q;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          if (misaligned) begin
            state_d   = ST_RSP;
            rsp_load  = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ, ST_WAIT: begin
        if (bus_done) begin
          state_d     = ST_RSP;
          rsp_load    = 1'b1;
          rsp_rdata_d = we_q ? 64'd0 : load_ext;
        end else if (timeout_hit) begin
          state_d   = ST_RSP;
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end else if ((state_q == ST_REQ) && !i_wb_stall) begin
          state_d = ST_WAIT;
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: request and response registers are reset too, since they drive ports that must read 0 out of reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      lane_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (req_fire) begin
        lane_q     <= i_req_addr[2:0];
        size_q     <= i_req_size;
        unsigned_q <= i_req_unsigned;
        we_q       <= i_req_we;
        adr_q      <= {i_req_addr[63:3], 3'b000};
        dat_q      <= lane_dat;
        sel_q      <= lane_sel;
      end
      if (rsp_load) begin
        rdata_q <= rsp_rdata_d;
        err_q   <= rsp_err_d;
      end
    end
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RSP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_wb_cyc    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign o_wb_stb    = (state_q == ST_REQ);
  assign o_wb_adr    = adr_q;
  assign o_wb_dat    = dat_q;
  assign o_wb_sel    = sel_q;
  assign o_wb_we     = we_q;

  // Configuration and bus-protocol invariants
  a_cnt_fits: assert property (@(posedge i_clk) 64'(TIMEOUT_CYCLES) < (64'd1 << CNT_BITS));

  a_stb_in_cyc: assert property (@(posedge i_clk) disable iff (!i_reset_n) o_wb_stb |-> o_wb_cyc);

  a_bus_stable: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (o_wb_cyc && $past(o_wb_cyc)) |-> $stable({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we}));

  a_rsp_pulse: assert property (@(posedge i_clk) disable iff (!i_reset_n) o_rsp_valid |=> !o_rsp_valid);

endmodule

// File: tb/tb_wb_master_port.sv
// tb_wb_master_port: table-driven vectors with a response scoreboard, plus stall/back-to-back/hang/reset sequences.
module tb_wb_master_port;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = 8;
`else
  localparam int unsigned TO_CYCLES = 255;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [63:0] wb_adr;
  logic [63:0] wb_dat_o;
  logic        wb_we;
  logic [7:0]  wb_sel;
  logic        wb_stb;
  logic        wb_cyc;
  logic [63:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0;
  logic        wb_stall = 1'b0;

  always #5 clk = ~clk;

  wb_master_port #(
    .TIMEOUT_CYCLES(TO_CYCLES),
    .CNT_BITS      (8)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_addr    (req_addr),
    .i_req_wdata   (req_wdata),
    .i_req_we      (req_we),
    .i_req_size    (req_size),
    .i_req_unsigned(req_unsigned),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_rdata   (rsp_rdata),
    .o_rsp_err     (rsp_err),
    .o_wb_adr      (wb_adr),
    .o_wb_dat      (wb_dat_o),
    .o_wb_we       (wb_we),
    .o_wb_sel      (wb_sel),
    .o_wb_stb      (wb_stb),
    .o_wb_cyc      (wb_cyc),
    .i_wb_dat      (wb_dat_i),
    .i_wb_ack      (wb_ack),
    .i_wb_stall    (wb_stall)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [7:0]  stall;
    logic [7:0]  waitc;
    logic [63:0] sdat;
    logic [7:0]  exp_sel;
    logic [63:0] exp_dat;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  localparam int NVEC = 15;

  vec_t vecs [NVEC];
  exp_t sb_q [$];
  exp_t mon_e;
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
  end

  // Called just after a rising edge with the DUT idle; returns the same way.
  task automatic do_txn(input int idx);
    vec_t        v;
    int          n;
    bit          got;
    int          stb_cnt;
    int          cyc_cnt;
    int          exp_lat;
    logic [63:0] exp_adr;
    v       = vecs[idx];
    exp_adr = {v.addr[63:3], 3'b000};
    exp_lat = v.exp_err ? 0 : int'(v.stall) + int'(v.waitc) + 1;

    req_valid    = 1'b1;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    wb_dat_i     = v.sdat;
    wb_stall     = 1'b0;
    wb_ack       = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_ready", idx), 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    sb_q.push_back('{rdata: v.exp_rdata, err: v.exp_err});

    n       = 0;
    got     = 1'b0;
    stb_cnt = 0;
    cyc_cnt = 0;
    while (!got && n < 64) begin
      wb_stall = !v.exp_err && (n < int'(v.stall));
      wb_ack   = !v.exp_err && (n == exp_lat - 1);
      @(negedge clk);
      if (wb_cyc) begin
        cyc_cnt++;
        if (wb_stb) stb_cnt++;
        check($sformatf("v%0d_adr", idx), wb_adr, exp_adr);
        check($sformatf("v%0d_sel", idx), 64'(wb_sel), 64'(v.exp_sel));
        check($sformatf("v%0d_we", idx), 64'(wb_we), 64'(v.we));
        if (v.we) check($sformatf("v%0d_dat", idx), wb_dat_o, v.exp_dat);
      end
      if (rsp_valid) begin
        got = 1'b1;
        check($sformatf("v%0d_latency", idx), 64'(n), 64'(exp_lat));
      end
      @(posedge clk);
      #1;
      n++;
    end
    wb_stall = 1'b0;
    wb_ack   = 1'b0;
    check($sformatf("v%0d_rsp_seen", idx), 64'(got), 64'd1);
    check($sformatf("v%0d_cyc_cycles", idx), 64'(cyc_cnt), 64'(exp_lat));
    check($sformatf("v%0d_stb_cycles", idx), 64'(stb_cnt),
          v.exp_err ? 64'd0 : 64'(int'(v.stall) + 1));
  endtask

  task automatic start_noack_load(input logic [63:0] addr);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_wdata    = '0;
    req_we       = 1'b0;
    req_size     = 2'd3;
    req_unsigned = 1'b0;
    wb_ack       = 1'b0;
    wb_stall     = 1'b0;
    wb_dat_i     = 64'hDEAD_DEAD_DEAD_DEAD;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int accepts;
    int cnt;
    bit got;

    //            addr        wdata                  we    size  uns   stall waitc sdat                   sel    exp_dat                exp_rdata              err
    vecs[0]  = '{64'h100, 64'h0,                  1'b0, 2'd3, 1'b0, 8'd0, 8'd0, 64'h1122334455667788, 8'hFF, 64'h0,                64'h1122334455667788, 1'b0};
    vecs[1]  = '{64'h103, 64'h0,                  1'b0, 2'd0, 1'b0, 8'd0, 8'd0, 64'h0000000080000000, 8'h08, 64'h0,                64'hFFFFFFFFFFFFFF80, 1'b0};
    vecs[2]  = '{64'h103, 64'h0,                  1'b0, 2'd0, 1'b1, 8'd1, 8'd0, 64'h0000000080000000, 8'h08, 64'h0,                64'h0000000000000080, 1'b0};
    vecs[3]  = '{64'h106, 64'hBEEF,               1'b1, 2'd1, 1'b0, 8'd3, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'hC0, 64'hBEEF000000000000, 64'h0,                1'b0};
    vecs[4]  = '{64'h102, 64'h0,                  1'b0, 2'd2, 1'b0, 8'd0, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0,                64'h0,                1'b1};
    vecs[5]  = '{64'h104, 64'h0,                  1'b0, 2'd2, 1'b0, 8'd0, 8'd2, 64'h8765432100000000, 8'hF0, 64'h0,                64'hFFFFFFFF87654321, 1'b0};
    vecs[6]  = '{64'h104, 64'h0,                  1'b0, 2'd2, 1'b1, 8'd1, 8'd1, 64'h8765432100000000, 8'hF0, 64'h0,                64'h0000000087654321, 1'b0};
    vecs[7]  = '{64'h002, 64'h0,                  1'b0, 2'd1, 1'b0, 8'd0, 8'd0, 64'h123456787FFF9ABC, 8'h0C, 64'h0,                64'h0000000000007FFF, 1'b0};
    vecs[8]  = '{64'h00E, 64'h0,                  1'b0, 2'd1, 1'b0, 8'd0, 8'd1, 64'hABCD111122223333, 8'hC0, 64'h0,                64'hFFFFFFFFFFFFABCD, 1'b0};
    vecs[9]  = '{64'h201, 64'h5A,                 1'b1, 2'd0, 1'b0, 8'd0, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'h02, 64'h0000000000005A00, 64'h0,                1'b0};
    vecs[10] = '{64'h308, 64'h0123456789ABCDEF,   1'b1, 2'd3, 1'b0, 8'd0, 8'd1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0123456789ABCDEF, 64'h0,                1'b0};
    vecs[11] = '{64'h304, 64'h0,                  1'b0, 2'd3, 1'b0, 8'd0, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0,                64'h0,                1'b1};
    vecs[12] = '{64'h101, 64'h1234,               1'b1, 2'd1, 1'b0, 8'd0, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0,                64'h0,                1'b1};
    vecs[13] = '{64'h107, 64'h0,                  1'b0, 2'd0, 1'b1, 8'd0, 8'd0, 64'hFF12345678ABCDEF, 8'h80, 64'h0,                64'h00000000000000FF, 1'b0};
    vecs[14] = '{64'h10C, 64'hDEADBEEF,           1'b1, 2'd2, 1'b0, 8'd2, 8'd0, 64'hFFFFFFFFFFFFFFFF, 8'hF0, 64'hDEADBEEF00000000, 64'h0,                1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_cyc", 64'(wb_cyc), 64'd0);
    check("rst_stb", 64'(wb_stb), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_adr", wb_adr, 64'd0);
    check("rst_sel", 64'(wb_sel), 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) do_txn(i);

    // Back-to-back: valid held high and ack held high (ack while idle is ignored)
    req_valid    = 1'b1;
    req_addr     = 64'h140;
    req_wdata    = '0;
    req_we       = 1'b0;
    req_size     = 2'd3;
    req_unsigned = 1'b0;
    wb_dat_i     = 64'hCAFEF00D12345678;
    wb_ack       = 1'b1;
    wb_stall     = 1'b0;
    accepts      = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (req_ready && req_valid) begin
        accepts++;
        sb_q.push_back('{rdata: 64'hCAFEF00D12345678, err: 1'b0});
      end
      @(posedge clk);
      #1;
      if (c == 8) req_valid = 1'b0;
    end
    wb_ack = 1'b0;
    check("b2b_accepts", 64'(accepts), 64'd3);
    check("b2b_drained", 64'(sb_q.size()), 64'd0);

    // Slave never acks
    start_noack_load(64'h180);
`ifdef WB_MASTER_TIMEOUT_EN
    sb_q.push_back('{rdata: 64'h0, err: 1'b1});
    cnt = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (wb_cyc) cnt++;
      if (rsp_valid) got = 1'b1;
      @(posedge clk);
      #1;
    end
    check("timeout_rsp_seen", 64'(got), 64'd1);
    check("timeout_cyc_cycles", 64'(cnt), 64'(TO_CYCLES));
    start_noack_load(64'h1C0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
`else
    cnt = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (wb_cyc) cnt++;
      @(posedge clk);
      #1;
    end
    check("hang_cyc_cycles", 64'(cnt), 64'd120);
`endif

    // Asynchronous reset while in WAIT
    check("pre_rst_cyc", 64'(wb_cyc), 64'd1);
    check("pre_rst_stb", 64'(wb_stb), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_cyc", 64'(wb_cyc), 64'd0);
    check("async_rst_stb", 64'(wb_stb), 64'd0);
    check("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd1);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_cyc", 64'(wb_cyc), 64'd0);
    @(posedge clk);
    #1;
    do_txn(0);
    do_txn(1);

    repeat (2) @(posedge clk);
    check("sb_empty_at_end", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
